regfile_wr_arbiter: RTL and testbench

//  Shares the single register-file write port (8 x 16-bit, r0 hardwired zero) among NUM_REQ writeback

---
 rtl/regfile_wr_arbiter_pkg.sv | 15 +
 rtl/regfile_wr_arbiter_wb_fifo.sv | 65 ++++++
 rtl/regfile_wr_arbiter.sv | 143 ++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared widths and helpers for the register-file writeback arbiter.
// The defaults match the 8 x 16-bit register file (r0 hardwired to zero).
package regfile_wr_arbiter_pkg;

  localparam int REG_ADDR_W  = 3;
  localparam int REG_DATA_W  = 16;
  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_DEPTH   = 2;

  // Round-robin successor that also works for non-power-of-two requester counts.
  function automatic int rr_next(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_wb_fifo.sv
// Per-requester writeback FIFO holding (dest, data) entries.
// Every slot's dest is exposed so the top can build the pending-write mask.
module regfile_wr_arbiter_wb_fifo #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [ADDR_W-1:0]        push_dest_i,
  input  logic [DATA_W-1:0]        push_data_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [ADDR_W-1:0]        head_dest_o,
  output logic [DATA_W-1:0]        head_data_o,
  output logic [DEPTH-1:0]         entry_vld_o,
  output logic [DEPTH*ADDR_W-1:0]  entry_dest_o
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] dest_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk) begin
    if (push_i) begin
      dest_mem[wr_ptr_q] <= push_dest_i;
      data_mem[wr_ptr_q] <= push_data_i;
    end
  end

  // Push is applied after pop so a same-slot push/pop leaves the slot occupied.
  always_comb begin
    vld_d = vld_q;
    if (pop_i)  vld_d[rd_ptr_q] = 1'b0;
    if (push_i) vld_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (push_i) wr_ptr_q <= PW'(wr_ptr_q + 1'b1);
      if (pop_i)  rd_ptr_q <= PW'(rd_ptr_q + 1'b1);
    end
  end

  assign full_o      = vld_q[wr_ptr_q];
  assign empty_o     = !vld_q[rd_ptr_q];
  assign head_dest_o = dest_mem[rd_ptr_q];
  assign head_data_o = data_mem[rd_ptr_q];
  assign entry_vld_o = vld_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    assign entry_dest_o[gi*ADDR_W +: ADDR_W] = dest_mem[gi];
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback requesters,
// with per-requester FIFOs, registered write outputs and a pending-write mask for interlock.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_dest,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic                         rg_wrt_enable,
  output logic [ADDR_W-1:0]            rg_wrt_dest,
  output logic [DATA_W-1:0]            rg_wrt_data,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic [(1<<ADDR_W)-1:0]       pending_mask
);

  localparam int NREGS = 1 << ADDR_W;
  localparam int GW    = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                  fifo_full, fifo_empty, push, pop;
  logic [ADDR_W-1:0]                   dest_a    [NUM_REQ];
  logic [DATA_W-1:0]                   data_a    [NUM_REQ];
  logic [ADDR_W-1:0]                   head_dest [NUM_REQ];
  logic [DATA_W-1:0]                   head_data [NUM_REQ];
  logic [NUM_REQ-1:0][DEPTH*ADDR_W-1:0] ent_dest;
  logic [NUM_REQ-1:0][DEPTH-1:0]       ent_vld;
  logic [NREGS-1:0]                    own_mask   [NUM_REQ];
  logic [NREGS-1:0]                    pend_other [NUM_REQ];
  logic [NREGS-1:0]                    claim_mask;

  logic                                win_vld;
  logic [GW-1:0]                       win_id;
  logic [GW-1:0]                       rr_q, rr_d;
  logic                                rg_wrt_enable_q;
  logic [ADDR_W-1:0]                   rg_wrt_dest_q;
  logic [DATA_W-1:0]                   rg_wrt_data_q;
  logic [GW-1:0]                       grant_id_q;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign dest_a[gi] = req_dest[gi*ADDR_W +: ADDR_W];
    assign data_a[gi] = req_data[gi*DATA_W +: DATA_W];
    // Writes to r0 are acknowledged but never stored.
    assign push[gi]   = req_valid[gi] && req_ready[gi] && (dest_a[gi] != '0);

    regfile_wr_arbiter_wb_fifo #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (push[gi]),
      .pop_i        (pop[gi]),
      .push_dest_i  (dest_a[gi]),
      .push_data_i  (data_a[gi]),
      .full_o       (fifo_full[gi]),
      .empty_o      (fifo_empty[gi]),
      .head_dest_o  (head_dest[gi]),
      .head_data_o  (head_data[gi]),
      .entry_vld_o  (ent_vld[gi]),
      .entry_dest_o (ent_dest[gi])
    );
  end

  // The write on rg_wrt_* still belongs to its requester until the register file commits it.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      own_mask[i] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        if (ent_vld[i][k]) own_mask[i][ent_dest[i][k*ADDR_W +: ADDR_W]] = 1'b1;
      end
      if (rg_wrt_enable_q && (int'(grant_id_q) == i)) own_mask[i][rg_wrt_dest_q] = 1'b1;
      pending_mask = pending_mask | own_mask[i];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_other[i] = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j != i) pend_other[i] = pend_other[i] | own_mask[j];
      end
    end
    pending_mask[0] = 1'b0;
  end

  // Lower-indexed requesters claim a dest first so two queues never own the same register.
  always_comb begin
    claim_mask = '0;
    req_ready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (dest_a[i] == '0) begin
        req_ready[i] = 1'b1;
      end else begin
        req_ready[i] = !fifo_full[i] && !pend_other[i][dest_a[i]] && !claim_mask[dest_a[i]];
        if (req_valid[i] && req_ready[i]) claim_mask[dest_a[i]] = 1'b1;
      end
    end
  end

  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    pop     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_vld && !fifo_empty[(int'(rr_q) + k) % NUM_REQ]) begin
        win_vld = 1'b1;
        win_id  = GW'((int'(rr_q) + k) % NUM_REQ);
      end
    end
    if (win_vld) pop[win_id] = 1'b1;
    rr_d = GW'(rr_next(int'(win_id), NUM_REQ));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rg_wrt_enable_q <= 1'b0;
      rg_wrt_dest_q   <= '0;
      rg_wrt_data_q   <= '0;
      grant_id_q      <= '0;
      rr_q            <= '0;
    end else begin
      rg_wrt_enable_q <= win_vld;
      if (win_vld) begin
        rg_wrt_dest_q <= head_dest[win_id];
        rg_wrt_data_q <= head_data[win_id];
        grant_id_q    <= win_id;
        rr_q          <= rr_d;
      end
    end
  end

  assign rg_wrt_enable = rg_wrt_enable_q;
  assign rg_wrt_dest   = rg_wrt_dest_q;
  assign rg_wrt_data   = rg_wrt_data_q;
  assign grant_id      = grant_id_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed vector table, hand sequences and random traffic
// checked against a queue-based model of the arbitration rules.
module tb_regfile_wr_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 3;
  localparam int DEPTH   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [5:0]  req_dest = '0;
  logic [31:0] req_data = '0;
  logic        rg_wrt_enable;
  logic [2:0]  rg_wrt_dest;
  logic [15:0] rg_wrt_data;
  logic        grant_id;
  logic [7:0]  pending_mask;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dest      (req_dest),
    .req_data      (req_data),
    .rg_wrt_enable (rg_wrt_enable),
    .rg_wrt_dest   (rg_wrt_dest),
    .rg_wrt_data   (rg_wrt_data),
    .grant_id      (grant_id),
    .pending_mask  (pending_mask)
  );

  int total = 0;
  int bad   = 0;

  // Register file built from what the DUT actually presents.
  logic [15:0] tb_rf [8] = '{default: 16'h0};
  int          wr_count = 0;
  always @(posedge clk) begin
    if (!rst && rg_wrt_enable) begin
      tb_rf[rg_wrt_dest] = rg_wrt_data;
      wr_count++;
    end
  end

  typedef struct packed {
    logic [2:0]  d;
    logic [15:0] v;
  } ent_t;

  ent_t        mq [2][$];
  int          m_rr;
  logic        m_en;
  logic [2:0]  m_dest;
  logic [15:0] m_data;
  int          m_gid;
  logic [15:0] m_rf [8] = '{default: 16'h0};

  logic [1:0]  obs_ready;
  logic        obs_en;
  logic [2:0]  obs_dest;
  logic [15:0] obs_data;
  logic        obs_gid;
  logic [7:0]  obs_pend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq[0].delete();
    mq[1].delete();
    m_rr   = 0;
    m_en   = 1'b0;
    m_dest = '0;
    m_data = '0;
    m_gid  = 0;
  endtask

  function automatic logic [1:0] model_ready(input logic [1:0] v, input logic [5:0] dd);
    logic [1:0] r;
    logic [2:0] d [2];
    bit blocked;
    d[0] = dd[2:0];
    d[1] = dd[5:3];
    r = '0;
    for (int i = 0; i < 2; i++) begin
      if (d[i] == 3'd0) begin
        r[i] = 1'b1;
      end else begin
        blocked = (mq[i].size() >= DEPTH);
        for (int j = 0; j < 2; j++) begin
          if (j != i) begin
            for (int k = 0; k < mq[j].size(); k++)
              if (mq[j][k].d == d[i]) blocked = 1'b1;
            if (m_en && m_gid == j && m_dest == d[i]) blocked = 1'b1;
          end
        end
        for (int j = 0; j < i; j++)
          if (v[j] && r[j] && d[j] == d[i]) blocked = 1'b1;
        r[i] = !blocked;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] model_pend();
    logic [7:0] p = '0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < mq[i].size(); k++) p[mq[i][k].d] = 1'b1;
    if (m_en) p[m_dest] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic model_step(input logic [1:0] v, input logic [5:0] dd, input logic [31:0] xx,
                            input logic [1:0] r);
    int   w = -1;
    ent_t e;
    for (int k = 0; k < 2; k++)
      if (w < 0 && mq[(m_rr + k) % 2].size() > 0) w = (m_rr + k) % 2;
    if (m_en) m_rf[m_dest] = m_data;
    for (int i = 0; i < 2; i++) begin
      if (v[i] && r[i] && dd[i*3 +: 3] != 3'd0) begin
        e.d = dd[i*3 +: 3];
        e.v = xx[i*16 +: 16];
        mq[i].push_back(e);
      end
    end
    if (w >= 0) begin
      e      = mq[w].pop_front();
      m_en   = 1'b1;
      m_dest = e.d;
      m_data = e.v;
      m_gid  = w;
      m_rr   = (w + 1) % 2;
    end else begin
      m_en = 1'b0;
    end
  endtask

  // Entered and left at posedge+1; outputs sampled at posedge+3.
  task automatic step(input logic [1:0] v, input logic [2:0] d0, input logic [15:0] x0,
                      input logic [2:0] d1, input logic [15:0] x1);
    logic [1:0] mr;
    req_valid = v;
    req_dest  = {d1, d0};
    req_data  = {x1, x0};
    #2;
    mr        = model_ready(v, req_dest);
    obs_ready = req_ready;
    obs_en    = rg_wrt_enable;
    obs_dest  = rg_wrt_dest;
    obs_data  = rg_wrt_data;
    obs_gid   = grant_id;
    obs_pend  = pending_mask;
    chk("ready", 32'(obs_ready), 32'(mr));
    chk("wr_en", 32'(obs_en), 32'(m_en));
    chk("wr_dest", 32'(obs_dest), 32'(m_dest));
    chk("wr_data", 32'(obs_data), 32'(m_data));
    chk("grant_id", 32'(obs_gid), 32'(m_gid));
    chk("pending", 32'(obs_pend), 32'(model_pend()));
    model_step(v, req_dest, req_data, mr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("rst_en", 32'(rg_wrt_enable), 32'd0);
    chk("rst_dest", 32'(rg_wrt_dest), 32'd0);
    chk("rst_data", 32'(rg_wrt_data), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_pend", 32'(pending_mask), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_en", 32'(rg_wrt_enable), 32'd0);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          rst_before;
    logic [1:0]  v;
    logic [2:0]  d0;
    logic [15:0] x0;
    logic [2:0]  d1;
    logic [15:0] x1;
    logic [1:0]  rdy;
    logic        en;
    logic [2:0]  dest;
    logic [15:0] data;
    logic        gid;
    logic [7:0]  pend;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int stalls;
    bit acc;
    int snap;

    // Single write to r3, then an r0 write, then two requesters streaming r1/r2.
    tbl[0]  = '{1'b0, 2'b01, 3'd3, 16'h1234, 3'd0, 16'h0000, 2'b11, 1'b0, 3'd0, 16'h0000, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 2'b11, 1'b0, 3'd0, 16'h0000, 1'b0, 8'h08};
    tbl[2]  = '{1'b0, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 2'b11, 1'b1, 3'd3, 16'h1234, 1'b0, 8'h08};
    tbl[3]  = '{1'b0, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 2'b11, 1'b0, 3'd3, 16'h1234, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 2'b01, 3'd0, 16'hFFFF, 3'd0, 16'h0000, 2'b11, 1'b0, 3'd3, 16'h1234, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 2'b11, 1'b0, 3'd3, 16'h1234, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 2'b11, 3'd1, 16'hA000, 3'd2, 16'hB000, 2'b11, 1'b0, 3'd0, 16'h0000, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 2'b11, 3'd1, 16'hA001, 3'd2, 16'hB001, 2'b11, 1'b0, 3'd0, 16'h0000, 1'b0, 8'h06};
    tbl[8]  = '{1'b0, 2'b11, 3'd1, 16'hA002, 3'd2, 16'hB002, 2'b01, 1'b1, 3'd1, 16'hA000, 1'b0, 8'h06};
    tbl[9]  = '{1'b0, 2'b11, 3'd1, 16'hA003, 3'd2, 16'hB002, 2'b10, 1'b1, 3'd2, 16'hB000, 1'b1, 8'h06};
    tbl[10] = '{1'b0, 2'b11, 3'd1, 16'hA003, 3'd2, 16'hB003, 2'b01, 1'b1, 3'd1, 16'hA001, 1'b0, 8'h06};
    tbl[11] = '{1'b0, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 2'b11, 1'b1, 3'd2, 16'hB001, 1'b1, 8'h06};
    tbl[12] = '{1'b0, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 2'b11, 1'b1, 3'd1, 16'hA002, 1'b0, 8'h06};
    tbl[13] = '{1'b0, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 2'b11, 1'b1, 3'd2, 16'hB002, 1'b1, 8'h06};
    tbl[14] = '{1'b0, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 2'b11, 1'b1, 3'd1, 16'hA003, 1'b0, 8'h02};
    tbl[15] = '{1'b0, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 2'b11, 1'b0, 3'd1, 16'hA003, 1'b0, 8'h00};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int n = 0; n < 16; n++) begin
      if (tbl[n].rst_before) do_reset();
      step(tbl[n].v, tbl[n].d0, tbl[n].x0, tbl[n].d1, tbl[n].x1);
      chk($sformatf("vec%0d_ready", n), 32'(obs_ready), 32'(tbl[n].rdy));
      chk($sformatf("vec%0d_en", n), 32'(obs_en), 32'(tbl[n].en));
      chk($sformatf("vec%0d_dest", n), 32'(obs_dest), 32'(tbl[n].dest));
      chk($sformatf("vec%0d_data", n), 32'(obs_data), 32'(tbl[n].data));
      chk($sformatf("vec%0d_gid", n), 32'(obs_gid), 32'(tbl[n].gid));
      chk($sformatf("vec%0d_pend", n), 32'(obs_pend), 32'(tbl[n].pend));
    end
    chk("rf_r3", 32'(tb_rf[3]), 32'h1234);
    chk("rf_r1", 32'(tb_rf[1]), 32'hA003);
    chk("rf_r2", 32'(tb_rf[2]), 32'hB002);

    // req1 to r5 must wait while req0 owns r5.
    do_reset();
    step(2'b01, 3'd5, 16'h0055, 3'd0, 16'h0000);
    step(2'b10, 3'd0, 16'h0000, 3'd5, 16'h1155);
    chk("hz5_blocked", 32'(obs_ready[1]), 32'd0);
    acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) begin
      step(2'b10, 3'd0, 16'h0000, 3'd5, 16'h1155);
      acc = obs_ready[1];
    end
    chk("hz5_accepted", 32'(acc), 32'd1);
    repeat (3) step(2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000);
    chk("hz5_final", 32'(tb_rf[5]), 32'h1155);

    // Same-cycle conflict on r4: req0 wins, req1 stalls.
    do_reset();
    step(2'b11, 3'd4, 16'h4440, 3'd4, 16'h4441);
    chk("cf4_ready", 32'(obs_ready), 32'h1);
    stalls = 0;
    acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) begin
      step(2'b10, 3'd0, 16'h0000, 3'd4, 16'h4441);
      acc = obs_ready[1];
      if (!acc) stalls++;
    end
    chk("cf4_accepted", 32'(acc), 32'd1);
    chk("cf4_stalled", 32'(stalls >= 1), 32'd1);
    repeat (3) step(2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000);
    chk("cf4_final", 32'(tb_rf[4]), 32'h4441);

    // Reset while queues are loaded: everything queued is dropped.
    do_reset();
    step(2'b11, 3'd1, 16'h6001, 3'd3, 16'h6003);
    step(2'b11, 3'd2, 16'h6002, 3'd5, 16'h6005);
    step(2'b11, 3'd6, 16'h6006, 3'd7, 16'h6007);
    do_reset();
    snap = wr_count;
    repeat (4) step(2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000);
    chk("rst_no_writes", 32'(wr_count), 32'(snap));
    step(2'b11, 3'd1, 16'h7001, 3'd2, 16'h7002);
    step(2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000);
    step(2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000);
    chk("rst_first_en", 32'(obs_en), 32'd1);
    chk("rst_first_gid", 32'(obs_gid), 32'd0);

    // Random traffic on a small dest range to provoke conflicts.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step(2'($urandom_range(0, 3)), 3'($urandom_range(0, 4)), 16'($urandom),
           3'($urandom_range(0, 4)), 16'($urandom));
    end
    repeat (8) step(2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000);
    for (int r = 1; r < 8; r++)
      chk($sformatf("rf_final_r%0d", r), 32'(tb_rf[r]), 32'(m_rf[r]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
